// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external memory bus between the instruction-fetch miss path
//   and the data-access path. One transaction is on the bus at a time. Data
//   wins simultaneous requests, but only for STARVE_LIMIT consecutive
//   grants while a fetch is waiting.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   inst_*            fetch request/address in; rdata/resp_addr/done/stall out
//   data_*            data request/we/wstrb/addr/wdata in; rdata/done/stall out
//   bus_*             req/we/wstrb/addr/wdata out; ack/rdata in
//
// Timing: a request is sampled in cycle 0. bus_req rises in cycle 1 and is
// held until bus_ack. The done pulse comes one cycle after the ack. The FSM
// then spends one RESP cycle before it can grant again.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic [ADDR_W-1:0]   inst_resp_addr,
  output logic                inst_done,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic                data_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, BUS_I, BUS_D, RESP_I, RESP_D} state_t;

  state_t              state_q, state_d;
  logic [3:0]          streak_q, streak_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [ADDR_W-1:0]   inst_resp_addr_q, inst_resp_addr_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_done_q, inst_done_d;
  logic                data_done_q, data_done_d;

  // A waiting fetch caps the data streak; with no fetch waiting, data always wins.
  logic data_grant;
  assign data_grant = data_req && (!inst_req || (streak_q < LIMIT));

  always_comb begin
    state_d          = state_q;
    streak_d         = streak_q;
    bus_req_d        = bus_req_q;
    bus_we_d         = bus_we_q;
    bus_wstrb_d      = bus_wstrb_q;
    bus_addr_d       = bus_addr_q;
    bus_wdata_d      = bus_wdata_q;
    inst_rdata_d     = inst_rdata_q;
    inst_resp_addr_d = inst_resp_addr_q;
    data_rdata_d     = data_rdata_q;
    inst_done_d      = 1'b0;
    data_done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_grant) begin
          state_d     = BUS_D;
          bus_req_d   = 1'b1;
          bus_we_d    = data_we;
          bus_wstrb_d = data_wstrb;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          // Count only grants that made a fetch wait, saturating at the limit.
          if (!inst_req)             streak_d = '0;
          else if (streak_q < LIMIT) streak_d = streak_q + 4'd1;
        end else if (inst_req) begin
          state_d     = BUS_I;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_wstrb_d = '1;
          bus_addr_d  = inst_addr;
          streak_d    = '0;
        end
      end
      BUS_I: begin
        if (bus_ack) begin
          state_d          = RESP_I;
          bus_req_d        = 1'b0;
          inst_rdata_d     = bus_rdata;
          inst_resp_addr_d = bus_addr_q;
          inst_done_d      = 1'b1;
        end
      end
      BUS_D: begin
        if (bus_ack) begin
          state_d      = RESP_D;
          bus_req_d    = 1'b0;
          data_rdata_d = bus_rdata;
          data_done_d  = 1'b1;
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      streak_q         <= '0;
      bus_req_q        <= 1'b0;
      bus_we_q         <= 1'b0;
      bus_wstrb_q      <= '0;
      bus_addr_q       <= '0;
      bus_wdata_q      <= '0;
      inst_rdata_q     <= '0;
      inst_resp_addr_q <= '0;
      data_rdata_q     <= '0;
      inst_done_q      <= 1'b0;
      data_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      streak_q         <= streak_d;
      bus_req_q        <= bus_req_d;
      bus_we_q         <= bus_we_d;
      bus_wstrb_q      <= bus_wstrb_d;
      bus_addr_q       <= bus_addr_d;
      bus_wdata_q      <= bus_wdata_d;
      inst_rdata_q     <= inst_rdata_d;
      inst_resp_addr_q <= inst_resp_addr_d;
      data_rdata_q     <= data_rdata_d;
      inst_done_q      <= inst_done_d;
      data_done_q      <= data_done_d;
    end
  end

  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_wstrb      = bus_wstrb_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign inst_rdata     = inst_rdata_q;
  assign inst_resp_addr = inst_resp_addr_q;
  assign data_rdata     = data_rdata_q;
  assign inst_done      = inst_done_q;
  assign data_done      = data_done_q;

  // The stalls follow the live request, so a withdrawn request stops stalling at once.
  assign inst_stall = inst_req & ~inst_done_q;
  assign data_stall = data_req & ~data_done_q;

endmodule
